// File: rtl/mem_stage.sv
// Memory stage: E->M pipeline register, load data alignment with stall hold,
// and exception prioritisation toward CP0.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_e,
    input  logic [31:0] aluout_e,
    input  logic [4:0]  writereg_e,
    input  logic [1:0]  controls_e,
    input  logic [5:0]  op_e,
    input  logic        hilo_write_e,
    input  logic [63:0] hilo_e,
    input  logic        cp0_write_e,
    input  logic [4:0]  rd_e,
    input  logic [7:0]  exception_code_e,
    input  logic [31:0] badaddr_e,
    input  logic        in_delayslot_e,
    input  logic        int_pending,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] pc_m,
    output logic [31:0] aluout_m,
    output logic [4:0]  writereg_m,
    output logic        regwrite_m,
    output logic        memtoreg_m,
    output logic [31:0] result_m,
    output logic        hilo_write_m,
    output logic [63:0] hilo_m,
    output logic        cp0_write_m,
    output logic [4:0]  rd_m,
    output logic        exc_valid_m,
    output logic [4:0]  exc_code_m,
    output logic [31:0] badvaddr_m,
    output logic        in_delayslot_m
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    logic        regwrite_r;
    logic        hilo_write_r;
    logic        cp0_write_r;
    logic [5:0]  op_m;
    logic [6:0]  exc_bits;
    logic        load;
    logic        fresh;
    logic [31:0] hold_data;
    logic        hold_valid;
    logic        unused_exc_bit;

    assign load = ~flush & ~stall;
    assign unused_exc_bit = exception_code_e[7];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_m           <= RESET_PC;
            aluout_m       <= '0;
            writereg_m     <= '0;
            regwrite_r     <= 1'b0;
            memtoreg_m     <= 1'b0;
            op_m           <= '0;
            hilo_write_r   <= 1'b0;
            hilo_m         <= '0;
            cp0_write_r    <= 1'b0;
            rd_m           <= '0;
            exc_bits       <= '0;
            badvaddr_m     <= '0;
            in_delayslot_m <= 1'b0;
        end else if (flush) begin
            pc_m           <= RESET_PC;
            aluout_m       <= '0;
            writereg_m     <= '0;
            regwrite_r     <= 1'b0;
            memtoreg_m     <= 1'b0;
            op_m           <= '0;
            hilo_write_r   <= 1'b0;
            hilo_m         <= '0;
            cp0_write_r    <= 1'b0;
            rd_m           <= '0;
            exc_bits       <= '0;
            badvaddr_m     <= '0;
            in_delayslot_m <= 1'b0;
        end else if (!stall) begin
            pc_m           <= pc_e;
            aluout_m       <= aluout_e;
            writereg_m     <= writereg_e;
            regwrite_r     <= controls_e[1];
            memtoreg_m     <= controls_e[0];
            op_m           <= op_e;
            hilo_write_r   <= hilo_write_e;
            hilo_m         <= hilo_e;
            cp0_write_r    <= cp0_write_e;
            rd_m           <= rd_e;
            exc_bits       <= exception_code_e[6:0];
            badvaddr_m     <= badaddr_e;
            in_delayslot_m <= in_delayslot_e;
        end
    end

    // The SRAM drives read data for one cycle only; capture it so a stalled
    // load keeps presenting the same value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fresh      <= 1'b0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else begin
            fresh <= load;
            if (flush || load) begin
                hold_valid <= 1'b0;
            end else if (fresh && !hold_valid) begin
                hold_data  <= data_sram_rdata;
                hold_valid <= 1'b1;
            end
        end
    end

    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_value;

    always_comb begin
        raw = hold_valid ? hold_data : data_sram_rdata;
        unique case (aluout_m[1:0])
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = aluout_m[1] ? raw[31:16] : raw[15:0];
        case (op_m)
            OP_LB:   load_value = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_value = {24'h0, byte_sel};
            OP_LH:   load_value = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_value = {16'h0, half_sel};
            default: load_value = raw;
        endcase
    end

    assign result_m = memtoreg_m ? load_value : aluout_m;

    logic inst_valid;

    // Interrupts are only taken on a real instruction, never on a bubble.
    assign inst_valid = (pc_m != RESET_PC) | regwrite_r | memtoreg_m
                      | hilo_write_r | cp0_write_r;

    always_comb begin
        exc_valid_m = 1'b1;
        exc_code_m  = 5'h00;
        if (int_pending && inst_valid) begin
            exc_code_m = EXC_INT;
        end else if (exc_bits[3]) begin
            exc_code_m = EXC_RI;
        end else if (exc_bits[2]) begin
            exc_code_m = EXC_SYS;
        end else if (exc_bits[1]) begin
            exc_code_m = EXC_BP;
        end else if (exc_bits[4]) begin
            exc_code_m = EXC_OV;
        end else if (exc_bits[6]) begin
            exc_code_m = EXC_ADEL;
        end else if (exc_bits[5]) begin
            exc_code_m = EXC_ADES;
        end else if (exc_bits[0]) begin
            exc_code_m = EXC_ERET;
        end else begin
            exc_valid_m = 1'b0;
        end
    end

    assign regwrite_m   = regwrite_r & ~exc_valid_m;
    assign hilo_write_m = hilo_write_r & ~exc_valid_m;
    assign cp0_write_m  = cp0_write_r & ~exc_valid_m;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected results per cycle,
// a negedge monitor pops and compares them.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall, flush;
    logic [31:0] pc_e, aluout_e;
    logic [4:0]  writereg_e;
    logic [1:0]  controls_e;
    logic [5:0]  op_e;
    logic        hilo_write_e;
    logic [63:0] hilo_e;
    logic        cp0_write_e;
    logic [4:0]  rd_e;
    logic [7:0]  exception_code_e;
    logic [31:0] badaddr_e;
    logic        in_delayslot_e;
    logic        int_pending;
    logic [31:0] data_sram_rdata;
    logic [31:0] pc_m, aluout_m, result_m, badvaddr_m;
    logic [4:0]  writereg_m, rd_m, exc_code_m;
    logic        regwrite_m, memtoreg_m, hilo_write_m, cp0_write_m;
    logic        exc_valid_m, in_delayslot_m;
    logic [63:0] hilo_m;

    mem_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .pc_e(pc_e), .aluout_e(aluout_e), .writereg_e(writereg_e),
        .controls_e(controls_e), .op_e(op_e),
        .hilo_write_e(hilo_write_e), .hilo_e(hilo_e),
        .cp0_write_e(cp0_write_e), .rd_e(rd_e),
        .exception_code_e(exception_code_e), .badaddr_e(badaddr_e),
        .in_delayslot_e(in_delayslot_e), .int_pending(int_pending),
        .data_sram_rdata(data_sram_rdata),
        .pc_m(pc_m), .aluout_m(aluout_m), .writereg_m(writereg_m),
        .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .result_m(result_m), .hilo_write_m(hilo_write_m),
        .hilo_m(hilo_m), .cp0_write_m(cp0_write_m), .rd_m(rd_m),
        .exc_valid_m(exc_valid_m), .exc_code_m(exc_code_m),
        .badvaddr_m(badvaddr_m), .in_delayslot_m(in_delayslot_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] result;
        logic        ev;
        logic [4:0]  code;
        logic        rw;
        logic [31:0] pc;
        logic        hv;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL %s: never checked (cycle %0d, now %0d)",
                     q[0].name, q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (result_m !== e.result || exc_valid_m !== e.ev ||
                exc_code_m !== e.code || regwrite_m !== e.rw ||
                pc_m !== e.pc || dut.hold_valid !== e.hv) begin
                bad++;
                $display("FAIL %s: got res=%h ev=%b code=%h rw=%b pc=%h hv=%b want res=%h ev=%b code=%h rw=%b pc=%h hv=%b",
                         e.name, result_m, exc_valid_m, exc_code_m,
                         regwrite_m, pc_m, dut.hold_valid,
                         e.result, e.ev, e.code, e.rw, e.pc, e.hv);
            end
        end
    end

    task automatic expect_now(input string name, input logic [31:0] res,
                              input logic ev, input logic [4:0] code,
                              input logic rw, input logic [31:0] pc,
                              input logic hv);
        exp_t e;
        e.cyc = cyc; e.name = name; e.result = res; e.ev = ev;
        e.code = code; e.rw = rw; e.pc = pc; e.hv = hv;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in E; it is captured at the next edge.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu,
                         input logic [5:0] op, input logic [1:0] ctrl,
                         input logic [7:0] exc);
        pc_e = pc; aluout_e = alu; op_e = op; controls_e = ctrl;
        exception_code_e = exc; writereg_e = 5'd3;
        stall = 1'b0; flush = 1'b0;
        step();
    endtask

    task automatic load_check(input string name, input logic [31:0] pc,
                              input logic [31:0] alu, input logic [5:0] op,
                              input logic [31:0] rdata,
                              input logic [31:0] res);
        issue(pc, alu, op, 2'b11, 8'h00);
        data_sram_rdata = rdata;
        expect_now(name, res, 1'b0, 5'h00, 1'b1, pc, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_e = '0; aluout_e = '0; writereg_e = '0; controls_e = '0;
        op_e = '0; hilo_write_e = 1'b0; hilo_e = '0; cp0_write_e = 1'b0;
        rd_e = '0; exception_code_e = '0; badaddr_e = '0;
        in_delayslot_e = 1'b0; int_pending = 1'b0; data_sram_rdata = '0;

        step();
        expect_now("reset_state", 32'h0, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1 resetn = 1'b1;

        load_check("lb", 32'h100, 32'h103, 6'h20, 32'h80FF_1234, 32'hFFFF_FF80);
        load_check("lbu", 32'h104, 32'h103, 6'h24, 32'h80FF_1234, 32'h0000_0080);
        load_check("lhu", 32'h108, 32'h202, 6'h25, 32'h9ABC_0000, 32'h0000_9ABC);
        load_check("lh", 32'h10c, 32'h202, 6'h21, 32'h9ABC_0000, 32'hFFFF_9ABC);
        load_check("lw", 32'h110, 32'h202, 6'h23, 32'h9ABC_0000, 32'h9ABC_0000);

        load_check("stall_c0", 32'h400, 32'h10, 6'h23, 32'h1111_2222, 32'h1111_2222);
        stall = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            data_sram_rdata = 32'hDEAD_BEEF;
            expect_now($sformatf("stall_c%0d", i), 32'h1111_2222,
                       1'b0, 5'h00, 1'b1, 32'h400, 1'b1);
        end

        issue(32'h500, 32'h1234, 6'h00, 2'b10, 8'h50);
        stall = 1'b1;
        expect_now("exc_ov_adel", 32'h1234, 1'b1, 5'h0c, 1'b0, 32'h500, 1'b0);
        step();
        int_pending = 1'b1;
        expect_now("exc_int", 32'h1234, 1'b1, 5'h00, 1'b0, 32'h500, 1'b1);
        flush = 1'b1;
        step();
        int_pending = 1'b0;
        flush = 1'b0;
        expect_now("flush_stall", 32'h0, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0);

        load_check("rst_pre", 32'h600, 32'h20, 6'h23, 32'h5566_7788, 32'h5566_7788);
        stall = 1'b1;
        step();
        data_sram_rdata = 32'hDEAD_BEEF;
        expect_now("rst_hold", 32'h5566_7788, 1'b0, 5'h00, 1'b1, 32'h600, 1'b1);
        step();
        #1 resetn = 1'b0;
        expect_now("rst_async", 32'h0, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0);
        #5 resetn = 1'b1;
        stall = 1'b0;
        pc_e = 32'h700; aluout_e = 32'h0; op_e = 6'h23; controls_e = 2'b11;
        exception_code_e = 8'h00;
        step();
        data_sram_rdata = 32'hCAFE_F00D;
        expect_now("post_rst_lw", 32'hCAFE_F00D, 1'b0, 5'h00, 1'b1, 32'h700, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, want finish");
        $fatal(1);
    end

endmodule
